dbus_sram_slave: RTL and testbench
==================================

// Module: dbus_sram_slave
// PURPOSE
//  Word-addressed SRAM responder for the core's data bus (dbus_req/we/addr/data/sel).
//  It is the slave end of the bus, replacing the zero-latency DPI pmem model in RTL-only builds.
//  It adds a programmable wait-state FSM, byte-lane write masking, an address-window check,
//  and a stall/ack handshake so the core's stall logic can be exercised.
// PARAMETERS
//  BASE_ADDR    32'h8000_0000  first byte address decoded by this slave
//  DEPTH        4096           memory size in 32-bit words (power of two)
//  WAIT_CYCLES  2              wait states between accept and ack (0..15)
// PORTS
//  clk      in   1   clock, all state on rising edge
//  rst_n    in   1   asynchronous active-low reset
//  req_i    in   1   access request (dbus_req)
//  we_i     in   1   1 = write, 0 = read
//  addr_i   in   32  byte address; bits [1:0] ignored (word access)
//  data_i   in   32  store data
//  sel_i    in   4   byte-lane enables; bit n -> data[8n+7:8n]
//  data_o   out  32  read data, valid when ack_o=1 and err_o=0
//  ack_o    out  1   single-cycle completion pulse
//  err_o    out  1   qualifies ack_o: access was outside the window
//  stall_o  out  1   slave busy; request not accepted this cycle
// BEHAVIOUR
//  Reset: state=IDLE; ack_o=0, err_o=0, stall_o=0, data_o=0, wait counter=0.
//    Memory array is not reset.
//  FSM states: IDLE, WAIT, RESP.
//  IDLE:
//    - req_i=1 accepts the request: latch we, addr, data, sel; compute in-range flag.
//    - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP. Counter is loaded with WAIT_CYCLES-1.
//    - req_i=0 stays in IDLE.
//  WAIT: counter decrements each cycle; go to RESP when it reaches 0.
//  RESP (exactly one cycle):
//    - ack_o=1; return to IDLE.
//    - In range and write: commit sel-masked bytes on the clock edge leaving RESP.
//      sel=0 writes nothing but still acks.
//    - In range and read: data_o = mem[idx]. Read data comes from the array as of the
//      start of RESP, so there are no bypass hazards.
//    - Out of range: err_o=1, data_o=0, no memory write.
//  stall_o = (state != IDLE). Inputs are ignored while stall_o=1. The initiator holds the
//    request until it sees ack_o; the slave latched it at accept.
//  Latency: ack_o is asserted WAIT_CYCLES+1 cycles after the accept edge.
//    Max throughput is one access per WAIT_CYCLES+2 cycles.
//  data_o holds its last value outside RESP; it is updated only on a read ack.
//  Range check: in range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH*4, using 33-bit compare,
//    no wrap. idx = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
//  Simultaneous events: req_i in the RESP cycle is not accepted (state != IDLE).
//    It is accepted on the following IDLE cycle if still high.
//  Reset mid-operation (WAIT or RESP): abort and return to IDLE.
//    A pending write is not committed and no ack is issued.
//  err_o is 0 whenever ack_o is 0.
// TESTING
//  1. WAIT_CYCLES=2. Write 0xDEADBEEF, sel=4'hF, to 0x8000_0010 at cycle 0
//     -> ack at cycle 3, err=0. Read of the same address -> ack with data_o=0xDEADBEEF.
//  2. Word 0x8000_0020 holds 0x11223344. Write 0xAABBCCDD with sel=4'b0101
//     -> read returns 0x11BB33DD.
//  3. Read 0x7FFF_FFFC and 0x8000_4000 (DEPTH=4096) -> ack with err_o=1, data_o=0.
//     Memory is unchanged; a read of 0x8000_0000 still returns the old value.
//  4. WAIT_CYCLES=0 with req_i held high for 6 cycles -> ack on cycles 1, 3, 5.
//     stall_o=1 on cycles 1, 3, 5.
//  5. Write issued, then rst_n pulsed low during WAIT
//     -> no ack; stall_o=0 immediately; a later read shows the old contents.
//  6. Write with addr_i=0x8000_0013 -> lands in the word at 0x8000_0010
//     (low bits ignored); readback matches.

Source files
------------

// File: rtl/dbus_sram_slave.sv
// dbus_sram_slave: word-addressed SRAM responder for the core data bus
// with programmable wait states, byte-lane writes and an address-window check.
module dbus_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI = LO + 33'(DEPTH) * 33'd4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            we_q, hit_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      sel_q;
  logic [31:0]     mem [DEPTH];
  logic            hit_d, hit_n, we_n, go_resp;
  logic [AW-1:0]   idx_d, idx_n;
  assign hit_d   = {1'b0, addr_i} >= LO && {1'b0, addr_i} < HI;
  assign idx_d   = AW'((addr_i - BASE_ADDR) >> 2);
  // With zero wait states the response is formed from the live inputs at accept.
  assign hit_n   = (state_q == IDLE) ? hit_d : hit_q;
  assign we_n    = (state_q == IDLE) ? we_i  : we_q;
  assign idx_n   = (state_q == IDLE) ? idx_d : idx_q;
  assign go_resp = (state_q == IDLE && req_i && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd0);
  assign stall_o = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      ack_o <= go_resp;
      err_o <= go_resp && !hit_n;
      if (go_resp && (!we_n || !hit_n))
        data_o <= hit_n ? mem[idx_n] : '0;
      case (state_q)
        IDLE: if (req_i) begin
          we_q    <= we_i;
          hit_q   <= hit_d;
          idx_q   <= idx_d;
          wdata_q <= data_i;
          sel_q   <= sel_i;
          cnt_q   <= 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
          state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt_q   <= (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
          state_q <= (cnt_q == 4'd0) ? RESP : WAIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  // Write commits on the edge leaving RESP; an async reset forces IDLE first.
  always_ff @(posedge clk)
    if (state_q == RESP && we_q && hit_q)
      for (int b = 0; b < 4; b++)
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
endmodule

// File: tb/tb_dbus_sram_slave.sv
// tb_dbus_sram_slave: randomized and directed checks of dbus_sram_slave
// against an associative-array memory model of the bus contract.
module tb_dbus_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 4096;
  localparam int W = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0] sel = '0;
  logic ack, err, stall;
  logic req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, rdata0;
  logic [3:0] sel0 = '0;
  logic ack0, err0, stall0;
  int vectors = 0, fails = 0;
  logic [31:0] model [int];
  always #5 clk = ~clk;
  dbus_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdata),
    .sel_i(sel), .data_o(rdata), .ack_o(ack), .err_o(err), .stall_o(stall));
  dbus_sram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0), .data_i(wdata0),
    .sel_i(sel0), .data_o(rdata0), .ack_o(ack0), .err_o(err0), .stall_o(stall0));

  function automatic bit in_win(input logic [31:0] a);
    longint x = longint'({32'h0, a});
    return x >= longint'({32'h0, BASE}) && x < longint'({32'h0, BASE}) + DEPTH * 4;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return in_win(a) ? model[widx(a)] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!in_win(a)) return;
    w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    model[widx(a)] = w;
  endtask

  // One bus transaction on the wait-state DUT; scrambles inputs while stalled.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; sel = s;
    lat = -1; rd = 'x; er = 'x;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (ack) begin
        lat = i; rd = rdata; er = err; req = 1'b0;
      end else begin
        vectors++;
        if (err !== 1'b0) begin fails++; $display("FAIL err_without_ack: err_o=%b required 0", err); end
        we = 1'($urandom); addr = $urandom; wdata = $urandom; sel = 4'($urandom);
      end
    end
    if (lat < 0) begin
      vectors++; fails++; req = 1'b0;
      $display("FAIL ack_timeout: no ack within 20 cycles for addr %h", a);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b required 0", ack); end
    vectors++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", err); end
    vectors++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b required 0", stall); end
    vectors++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_data: got %h required 0", rdata); end
    vectors++; if ({ack0, err0, stall0} !== 3'b000) begin fails++; $display("FAIL reset_dut0: got %b required 000", {ack0, err0, stall0}); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    vectors++; if (lat != W + 1) begin fails++; $display("FAIL wr_latency: got %0d required %0d", lat, W + 1); end
    vectors++; if (er !== 1'b0) begin fails++; $display("FAIL wr_err: got %b required 0", er); end
    access(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    vectors++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data: got %h required DEADBEEF", rd); end
    vectors++; if (lat != W + 1 || er !== 1'b0) begin fails++; $display("FAIL rd_resp: lat %0d err %b required %0d/0", lat, er, W + 1); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, rd, er, lat);
    model_write(32'h8000_0020, 32'h1122_3344, 4'hF);
    access(1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    model_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101);
    access(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    vectors++; if (lat != W + 1) begin fails++; $display("FAIL sel0_ack: latency %0d required %0d", lat, W + 1); end
    access(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat);
    vectors++; if (rd !== 32'h11BB_33DD) begin fails++; $display("FAIL byte_mask: got %h required 11BB33DD", rd); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic er; int lat;
    logic [31:0] bad [3] = '{32'h7FFF_FFFC, 32'h8000_4000, 32'hFFFF_FFFC};
    access(1'b1, BASE, 32'h5A5A_1234, 4'hF, rd, er, lat);
    model_write(BASE, 32'h5A5A_1234, 4'hF);
    foreach (bad[i]) begin
      access(1'b0, bad[i], 32'h0, 4'h0, rd, er, lat);
      vectors++; if (er !== 1'b1 || rd !== 32'h0 || lat != W + 1) begin
        fails++; $display("FAIL oor_read %h: err %b data %h lat %0d required 1/0/%0d", bad[i], er, rd, lat, W + 1);
      end
    end
    access(1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    vectors++; if (er !== 1'b1) begin fails++; $display("FAIL oor_write_err: got %b required 1", er); end
    access(1'b0, BASE, 32'h0, 4'h0, rd, er, lat);
    vectors++; if (rd !== 32'h5A5A_1234 || er !== 1'b0) begin fails++; $display("FAIL oor_no_write: got %h/%b required 5A5A1234/0", rd, er); end
    access(1'b1, 32'h8000_3FFC, 32'h0F0F_A5A5, 4'hF, rd, er, lat);
    model_write(32'h8000_3FFC, 32'h0F0F_A5A5, 4'hF);
    access(1'b0, 32'h8000_3FFC, 32'h0, 4'h0, rd, er, lat);
    vectors++; if (rd !== 32'h0F0F_A5A5 || er !== 1'b0) begin fails++; $display("FAIL last_word: got %h/%b required 0F0FA5A5/0", rd, er); end
  endtask

  task automatic test_zero_wait;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = BASE + 32'h40; wdata0 = 32'hCAFE_F00D; sel0 = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vectors++; if (ack0 !== 1'(k % 2) || stall0 !== 1'(k % 2) || err0 !== 1'b0) begin
        fails++; $display("FAIL zero_wait cycle %0d: ack %b stall %b err %b required %0d/%0d/0", k, ack0, stall0, err0, k % 2, k % 2);
      end
    end
    we0 = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    vectors++; if (ack0 !== 1'b1 || rdata0 !== 32'hCAFE_F00D) begin
      fails++; $display("FAIL zero_wait_read: ack %b data %h required 1/CAFEF00D", ack0, rdata0);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp = model_read(32'h8000_0020);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h8000_0020; sel = 4'h0;
    for (int k = 1; k <= 3 * (W + 2); k++) begin
      @(negedge clk);
      vectors++; if (ack !== 1'(k % (W + 2) == W + 1) || stall !== 1'(k % (W + 2) != 0)) begin
        fails++; $display("FAIL b2b cycle %0d: ack %b stall %b", k, ack, stall);
      end
      if (ack) begin
        vectors++; if (rdata !== exp) begin fails++; $display("FAIL b2b_data: got %h required %h", rdata, exp); end
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, BASE + 32'h80, 32'h0BAD_CAFE, 4'hF, rd, er, lat);
    model_write(BASE + 32'h80, 32'h0BAD_CAFE, 4'hF);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = BASE + 32'h80; wdata = 32'h1234_5678; sel = 4'hF;
    @(negedge clk);
    req = 1'b0;
    vectors++; if (stall !== 1'b1) begin fails++; $display("FAIL mid_stall_before: got %b required 1", stall); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (stall !== 1'b0 || ack !== 1'b0) begin fails++; $display("FAIL mid_reset_async: stall %b ack %b required 0/0", stall, ack); end
    repeat (3) begin
      @(negedge clk);
      vectors++; if (ack !== 1'b0) begin fails++; $display("FAIL mid_reset_ack: got %b required 0", ack); end
    end
    rst_n = 1'b1;
    access(1'b0, BASE + 32'h80, 32'h0, 4'h0, rd, er, lat);
    vectors++; if (rd !== 32'h0BAD_CAFE) begin fails++; $display("FAIL mid_reset_data: got %h required 0BADCAFE", rd); end
  endtask

  task automatic test_low_bits;
    logic [31:0] rd; logic er; int lat;
    access(1'b1, 32'h8000_0013, 32'h7654_3210, 4'hF, rd, er, lat);
    model_write(32'h8000_0013, 32'h7654_3210, 4'hF);
    access(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    vectors++; if (rd !== 32'h7654_3210) begin fails++; $display("FAIL low_bits: got %h required 76543210", rd); end
    access(1'b0, 32'h8000_0016, 32'h0, 4'h0, rd, er, lat);
    vectors++; if (rd !== model_read(32'h8000_0014)) begin fails++; $display("FAIL low_bits_next: got %h required %h", rd, model_read(32'h8000_0014)); end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d; logic er, w; logic [3:0] s; int lat;
    int idx [12];
    idx[0] = 0; idx[1] = DEPTH - 1; idx[2] = 5;
    for (int i = 3; i < 12; i++) idx[i] = int'($urandom_range(6, DEPTH - 2));
    foreach (idx[i]) begin
      a = BASE + 32'(idx[i] * 4); d = $urandom;
      access(1'b1, a, d, 4'hF, rd, er, lat);
      model_write(a, d, 4'hF);
    end
    for (int n = 0; n < 40; n++) begin
      a = BASE + 32'(idx[$urandom_range(0, 11)] * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0)
        a = $urandom_range(0, 1) ? 32'($urandom_range(0, 32'h7FFF_FFFF)) : 32'h8000_4000 + 32'($urandom_range(0, 32'h7FFF_BFFF));
      w = 1'($urandom); d = $urandom; s = 4'($urandom);
      access(w, a, d, s, rd, er, lat);
      vectors++; if (er !== !in_win(a) || lat != W + 1) begin
        fails++; $display("FAIL rand_resp %h: err %b lat %0d required %b/%0d", a, er, lat, !in_win(a), W + 1);
      end
      if (!w) begin
        vectors++; if (rd !== model_read(a)) begin fails++; $display("FAIL rand_read %h: got %h required %h", a, rd, model_read(a)); end
      end else model_write(a, d, s);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_lanes;
    test_out_of_range;
    test_zero_wait;
    test_back_to_back;
    test_reset_mid;
    test_low_bits;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
